// File: rtl/round_key_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : round_key_sequencer_if
// Brief   : Key-capture, start and round-key stream signals of the sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface round_key_sequencer_if;
  logic [0:1919] round_keys_i;
  logic          key_load_i;
  logic          key_ready_o;
  logic          start_v_i;
  logic          decrypt_i;
  logic          start_ready_o;
  logic [127:0]  rk_o;
  logic          rk_v_o;
  logic          rk_ready_i;
  logic [3:0]    round_o;
  logic          first_o;
  logic          last_o;
  logic          busy_o;

  modport slave (
    input  round_keys_i, key_load_i, start_v_i, decrypt_i, rk_ready_i,
    output key_ready_o, start_ready_o, rk_o, rk_v_o, round_o, first_o, last_o, busy_o
  );

  modport master (
    output round_keys_i, key_load_i, start_v_i, decrypt_i, rk_ready_i,
    input  key_ready_o, start_ready_o, rk_o, rk_v_o, round_o, first_o, last_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/round_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : round_key_sequencer
// Brief   : Captures a settled 15-entry round-key set and streams it forward
//           or reversed over a valid/ready handshake.
// Revision: 1.0  initial release
// ============================================================================
module round_key_sequencer #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  wire logic             clk_i,
  input  wire logic             reset_i,
  round_key_sequencer_if.slave  bus
);

  localparam logic [1:0] c_ST_NO_KEY = 2'd0;
  localparam logic [1:0] c_ST_SETTLE = 2'd1;
  localparam logic [1:0] c_ST_READY  = 2'd2;
  localparam logic [1:0] c_ST_STREAM = 2'd3;

  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_ROUND_MAX   = 4'd14;

  logic [1:0]    r_state;
  logic [3:0]    r_settle_cnt;
  logic [3:0]    r_round;
  logic          r_decrypt;
  logic [0:1919] r_keys;

  logic          w_in_ready;
  logic          w_in_stream;
  logic          w_in_settle;
  logic          w_capture;
  logic [3:0]    w_round_first;
  logic [3:0]    w_round_last;
  logic [127:0]  w_key [0:14];

  assign w_in_ready    = (r_state == c_ST_READY);
  assign w_in_stream   = (r_state == c_ST_STREAM);
  assign w_in_settle   = (r_state == c_ST_SETTLE);
  // A fresh key_load_i in the final settle cycle restarts rather than captures
  assign w_capture     = w_in_settle && (r_settle_cnt == c_SETTLE_LAST) && !bus.key_load_i;
  assign w_round_first = r_decrypt ? c_ROUND_MAX : 4'd0;
  assign w_round_last  = r_decrypt ? 4'd0 : c_ROUND_MAX;

  for (genvar gi = 0; gi < 15; gi++) begin : g_key_slice
    assign w_key[gi] = r_keys[gi*128 +: 128];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= c_ST_NO_KEY;
      r_settle_cnt <= 4'd0;
      r_round      <= 4'd0;
      r_decrypt    <= 1'b0;
    end else if (bus.key_load_i) begin
      r_state      <= c_ST_SETTLE;
      r_settle_cnt <= 4'd0;
      r_round      <= 4'd0;
    end else begin
      case (r_state)
        c_ST_SETTLE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_state <= c_ST_READY;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        c_ST_READY: begin
          if (bus.start_v_i) begin
            r_state   <= c_ST_STREAM;
            r_decrypt <= bus.decrypt_i;
            r_round   <= bus.decrypt_i ? c_ROUND_MAX : 4'd0;
          end
        end
        c_ST_STREAM: begin
          if (bus.rk_ready_i) begin
            if (r_round == w_round_last) begin
              r_state <= c_ST_READY;
              r_round <= 4'd0;
            end else if (r_decrypt) begin
              r_round <= r_round - 4'd1;
            end else begin
              r_round <= r_round + 4'd1;
            end
          end
        end
        default: begin
          r_state <= c_ST_NO_KEY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_keys <= '0;
    end else if (w_capture) begin
      r_keys <= bus.round_keys_i;
    end
  end

  // Stream outputs are forced to zero outside STREAM so idle cycles carry no key
  always_comb begin
    bus.key_ready_o   = w_in_ready || w_in_stream;
    bus.start_ready_o = w_in_ready && !bus.key_load_i;
    bus.busy_o        = w_in_settle || w_in_stream;
    bus.rk_v_o        = w_in_stream;
    bus.rk_o          = '0;
    bus.round_o       = 4'd0;
    bus.first_o       = 1'b0;
    bus.last_o        = 1'b0;
    if (w_in_stream) begin
      bus.rk_o    = w_key[r_round];
      bus.round_o = r_round;
      bus.first_o = (r_round == w_round_first);
      bus.last_o  = (r_round == w_round_last);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_round_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_round_key_sequencer
// Brief   : Randomized self-checking bench with a queue-based reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_round_key_sequencer;

  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  round_key_sequencer_if bus();

  round_key_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int           n_cmp = 0;
  int           n_err = 0;
  int           hs_cnt = 0;
  logic [127:0] cur_keys [15];
  logic [127:0] m_keys   [15];
  int           m_q [$];
  bit           m_have;
  int           m_settle;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_keys();
    logic [0:1919] b;
    b = {cur_keys[0], cur_keys[1], cur_keys[2], cur_keys[3], cur_keys[4],
         cur_keys[5], cur_keys[6], cur_keys[7], cur_keys[8], cur_keys[9],
         cur_keys[10], cur_keys[11], cur_keys[12], cur_keys[13], cur_keys[14]};
    bus.round_keys_i = b;
  endtask

  task automatic new_keys();
    for (int k = 0; k < 15; k++) cur_keys[k] = {$urandom, $urandom, $urandom, $urandom};
    drive_keys();
  endtask

  task automatic m_clear();
    m_q.delete();
    m_have   = 1'b0;
    m_settle = 0;
    for (int k = 0; k < 15; k++) m_keys[k] = '0;
  endtask

  task automatic check_outputs();
    bit           strm;
    logic [127:0] e_round;
    logic [127:0] e_rk;
    if (rst) m_clear();
    strm    = (m_q.size() > 0);
    e_round = '0;
    e_rk    = '0;
    if (strm) begin
      e_round = 128'(m_q[0]);
      e_rk    = m_keys[m_q[0]];
    end
    chk("rk_v",        128'(bus.rk_v_o),        128'(strm));
    chk("round",       128'(bus.round_o),       e_round);
    chk("rk",          bus.rk_o,                e_rk);
    chk("first",       128'(bus.first_o),       128'(strm && m_q.size() == 15));
    chk("last",        128'(bus.last_o),        128'(strm && m_q.size() == 1));
    chk("key_ready",   128'(bus.key_ready_o),   128'(m_have));
    chk("start_ready", 128'(bus.start_ready_o), 128'(m_have && !strm && !bus.key_load_i));
    chk("busy",        128'(bus.busy_o),        128'(m_settle > 0 || strm));
    if (bus.rk_v_o && bus.rk_ready_i) hs_cnt++;
  endtask

  task automatic model_step();
    if (rst) begin
      m_clear();
    end else if (bus.key_load_i) begin
      m_have   = 1'b0;
      m_q.delete();
      m_settle = SETTLE;
    end else if (m_settle > 0) begin
      m_settle--;
      if (m_settle == 0) begin
        m_keys = cur_keys;
        m_have = 1'b1;
      end
    end else if (m_have) begin
      if (m_q.size() > 0) begin
        if (bus.rk_ready_i) void'(m_q.pop_front());
      end else if (bus.start_v_i) begin
        for (int i = 0; i < 15; i++) m_q.push_back(bus.decrypt_i ? 14 - i : i);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.key_load_i = 1'b0;
    bus.start_v_i  = 1'b0;
    bus.decrypt_i  = 1'b0;
    bus.rk_ready_i = 1'b0;
  endtask

  task automatic load_and_settle();
    bus.key_load_i = 1'b1;
    cycle();
    bus.key_load_i = 1'b0;
    repeat (SETTLE + 1) cycle();
  endtask

  // mode 0: always ready, 1: toggling from ready, 2: random
  task automatic run_stream(input int mode, input int budget);
    int n = 0;
    while (m_q.size() > 0 && n < budget) begin
      case (mode)
        0:       bus.rk_ready_i = 1'b1;
        1:       bus.rk_ready_i = (n % 2 == 0);
        default: bus.rk_ready_i = 1'($urandom_range(0, 1));
      endcase
      cycle();
      n++;
    end
    chk("stream_done", 128'(m_q.size()), 128'(0));
    bus.rk_ready_i = 1'b0;
  endtask

  task automatic start_stream(input bit dec);
    bus.start_v_i = 1'b1;
    bus.decrypt_i = dec;
    cycle();
    bus.start_v_i = 1'b0;
    bus.decrypt_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    new_keys();
    m_clear();
    #1;
    repeat (2) cycle();
    bus.key_load_i = 1'b1;
    bus.start_v_i  = 1'b1;
    cycle();
    idle_inputs();
    rst = 1'b0;
    repeat (2) cycle();

    // Capture samples the bus in the last settle cycle; later changes are ignored
    bus.key_load_i = 1'b1;
    cycle();
    bus.key_load_i = 1'b0;
    cycle();
    new_keys();
    cycle();
    new_keys();
    cycle();

    hs_cnt = 0;
    start_stream(1'b0);
    run_stream(0, 40);
    chk("enc_hs", 128'(hs_cnt), 128'(15));
    cycle();

    hs_cnt = 0;
    start_stream(1'b1);
    run_stream(1, 60);
    chk("dec_hs", 128'(hs_cnt), 128'(15));
    cycle();

    // Abort at round 5, then change keys before the new capture
    start_stream(1'b0);
    begin
      int n = 0;
      bus.rk_ready_i = 1'b1;
      while (m_q.size() > 0 && m_q[0] != 5 && n < 20) begin
        cycle();
        n++;
      end
      chk("reach_r5", 128'(bus.round_o), 128'(5));
    end
    bus.rk_ready_i = 1'b0;
    bus.key_load_i = 1'b1;
    new_keys();
    cycle();
    bus.key_load_i = 1'b0;
    new_keys();
    repeat (SETTLE + 1) cycle();
    start_stream(1'b0);
    run_stream(2, 80);
    cycle();

    // Load and start together, then a restart during settle
    bus.key_load_i = 1'b1;
    bus.start_v_i  = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    bus.key_load_i = 1'b1;
    cycle();
    bus.key_load_i = 1'b0;
    new_keys();
    repeat (SETTLE + 2) cycle();

    // Asynchronous reset mid-stream
    start_stream(1'b1);
    bus.rk_ready_i = 1'b1;
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    chk("rst_rk_v",  128'(bus.rk_v_o),        128'(0));
    chk("rst_rk",    bus.rk_o,                128'(0));
    chk("rst_kready",128'(bus.key_ready_o),   128'(0));
    chk("rst_busy",  128'(bus.busy_o),        128'(0));
    chk("rst_round", 128'(bus.round_o),       128'(0));
    cycle();
    rst = 1'b0;
    bus.rk_ready_i = 1'b1;
    bus.start_v_i  = 1'b1;
    repeat (5) cycle();
    idle_inputs();
    load_and_settle();

    for (int i = 0; i < 2000; i++) begin
      bus.key_load_i = ($urandom_range(0, 99) < 3);
      bus.start_v_i  = ($urandom_range(0, 99) < 40);
      bus.decrypt_i  = 1'($urandom_range(0, 1));
      bus.rk_ready_i = ($urandom_range(0, 99) < 70);
      rst            = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) < 10) new_keys();
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
